// File: rtl/irrigacao_seq.sv
// irrigacao_seq: sequential irrigation controller.
// Waters the enabled zones one after another, lowest index first. Each zone
// stays open for the duration selected by the mode. A low tank level stops
// the cycle, and abort cancels it from any state.
// Every output is a register. Outputs follow the state one cycle later, but
// abort and low tank close the valves on the same edge that detects them.
// Optional feature: define IRRIG_LOWTANK_PAUSE_EN to pause on a low tank
// instead of faulting.
module irrigacao_seq #(
    parameter int NZ = 4,
    parameter int TW = 16,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [NZ-1:0] zone_en,
    input  logic [TW-1:0] dur_as,
    input  logic [TW-1:0] dur_gt,
    input  logic [LW-1:0] lvl,
    input  logic [LW-1:0] lvl_min,
    output logic [NZ-1:0] valve,
    output logic          pump,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    zone,
    output logic [6:0]    seg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_AS   = 2'b01;
    localparam logic [1:0] MODE_GT   = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_D   = 7'b1011110;
    localparam logic [6:0] SEG_P   = 7'b1110011;
    localparam logic [6:0] SEG_E   = 7'b1111001;

    state_t        state_q, state_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic [NZ-1:0] rem_q, rem_nxt;      // enabled zones not yet served
    logic [TW-1:0] dur_q, dur_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    logic [2:0]    zone_q, zone_nxt;

    logic          lvl_low;
    logic          found;
    logic [2:0]    pick;
    logic [NZ-1:0] pick_mask;
    logic [TW-1:0] sel_dur;

    state_t        view;                // state the outputs will show next cycle
    logic          kill;                // close the valves on this edge
    logic [NZ-1:0] valve_nxt;
    logic          pump_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          err_nxt;
    logic [2:0]    zone_out_nxt;
    logic [6:0]    seg_nxt;

    // Next-state and datapath: start outcome, zone selection, timer countdown.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        state_nxt = state_q;
        mode_nxt  = mode_q;
        rem_nxt   = rem_q;
        dur_nxt   = dur_q;
        timer_nxt = timer_q;
        zone_nxt  = zone_q;

        lvl_low = (lvl < lvl_min);
        sel_dur = (mode == MODE_AS) ? dur_as : dur_gt;

        found     = 1'b0;
        pick      = '0;
        pick_mask = '0;
        for (int i = 0; i < NZ; i++) begin
            if (rem_q[i] && !found) begin
                found        = 1'b1;
                pick         = 3'(i);
                pick_mask[i] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && mode != MODE_NONE) begin
                    mode_nxt  = mode;
                    rem_nxt   = zone_en;
                    dur_nxt   = sel_dur;
                    zone_nxt  = '0;
                    timer_nxt = '0;
                    if (mode == MODE_BAD || lvl_low)
                        state_nxt = S_ERR;
                    else if (zone_en == '0 || sel_dur == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                if (found) begin
                    zone_nxt  = pick;
                    rem_nxt   = rem_q & ~pick_mask;
                    timer_nxt = dur_q;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_RUN: begin
                if (lvl_low) begin
`ifdef IRRIG_LOWTANK_PAUSE_EN
                    state_nxt = S_PAUSE;
`else
                    state_nxt = S_ERR;
`endif
                end else begin
                    timer_nxt = timer_q - TW'(1);
                    if (timer_q == TW'(1))
                        state_nxt = S_SEL;
                end
            end
            S_PAUSE: begin
                // Timer stays frozen; the same zone resumes with its remaining time.
                if (!lvl_low)
                    state_nxt = S_RUN;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase

        if (state_q != S_IDLE && abort) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end
    end

    // Output decode: what the output registers load on this edge.
    always_comb begin
        view = state_q;
        if (state_q != S_IDLE && abort)
            view = S_IDLE;
        kill = (state_q == S_RUN) && lvl_low;

        pump_nxt = (view == S_RUN) && !kill;
        for (int i = 0; i < NZ; i++)
            valve_nxt[i] = pump_nxt && (zone_q == 3'(i));

        busy_nxt     = (view != S_IDLE);
        done_nxt     = (view == S_DONE);
        err_nxt      = (view == S_ERR);
        zone_out_nxt = (view == S_IDLE) ? 3'd0 : zone_q;

        case (view)
            S_SEL, S_RUN, S_DONE: begin
                if (mode_q == MODE_AS)
                    seg_nxt = SEG_A;
                else if (mode_q == MODE_GT)
                    seg_nxt = SEG_D;
                else
                    seg_nxt = SEG_OFF;
            end
            S_PAUSE: seg_nxt = SEG_P;
            S_ERR:   seg_nxt = SEG_E;
            default: seg_nxt = SEG_OFF;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
            dur_q   <= '0;
            timer_q <= '0;
            zone_q  <= '0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            rem_q   <= rem_nxt;
            dur_q   <= dur_nxt;
            timer_q <= timer_nxt;
            zone_q  <= zone_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valve <= '0;
            pump  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            zone  <= '0;
            seg   <= '0;
        end else begin
            valve <= valve_nxt;
            pump  <= pump_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            zone  <= zone_out_nxt;
            seg   <= seg_nxt;
        end
    end

endmodule
